nios2_oci_trace_capture: RTL and testbench
==========================================

Name: nios2_oci_trace_capture

Overview:
Parametrised capture engine for the Nios II OCI debug-trace (DCT) stream during simulation and bring-up. It accepts packed multi-slot DCT buffer words with a valid-slot count, serialises the valid slots into a local FIFO, and exposes them on a simple read port. It also tracks test-end sequencing (ending, then ended) with sticky error flags. It sits beside the OCI block in the limbus subsystem and replaces the passive, port-only test-bench stub.

Parameters:
SLOT_W, 10, width of one DCT trace slot
SLOTS, 3, slots per dct_buffer word (dct_buffer width = SLOT_W*SLOTS)
CNT_W, 4, width of dct_count
DEPTH, 16, FIFO depth in slots; power of 2, minimum 4
DROP_W, 16, width of the dropped-slot counter

Ports:
clk  in  1  sole clock
reset_n  in  1  asynchronous, active-low reset
dct_buffer  in  SLOT_W*SLOTS  packed slots; slot 0 in the LSBs
dct_count  in  CNT_W  number of valid slots in dct_buffer, counted from slot 0
dct_valid  in  1  offer of dct_buffer/dct_count
dct_ready  out  1  capture engine can accept
test_ending  in  1  level; request to stop accepting
test_has_ended  in  1  level; force final state
rd_en  in  1  pop request
rd_data  out  SLOT_W  popped slot
rd_valid  out  1  rd_data valid, single-cycle pulse
fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky; at least one slot dropped
count_err  out  1  sticky; dct_count exceeded SLOTS
dropped  out  DROP_W  saturating count of dropped slots
state  out  2  0=RUN, 1=ENDING, 2=ENDED
done  out  1  high in ENDED

Behaviour:
- Reset (async assert, sync release): state=RUN, FIFO empty, all outputs 0 except dct_ready=1.
- Accept: a word is accepted on a clock edge where dct_valid and dct_ready are both high. The buffer and the clamped count n=min(dct_count,SLOTS) are latched.
- If dct_count>SLOTS: count_err is set (sticky) and the word is processed as SLOTS slots.
- Serialiser: slot k is pushed on edge t+1+k for k=0..n-1. dct_ready=0 while any slot of the latched word is pending. It rises in the cycle after the last push.
- If n=0: nothing is pushed and dct_ready stays high.
- dct_ready = (state==RUN) and serialiser idle.
- Push when FIFO full and no pop on the same edge: the slot is dropped, overflow is set, and dropped increments, saturating at all-ones. Serialisation continues with the next slot regardless.
- Simultaneous push and pop when full: both occur and fifo_level is unchanged.
- Read: rd_en with FIFO non-empty pops the head. rd_data/rd_valid are registered, so rd_valid=1 on the cycle after rd_en. rd_data holds its value until the next pop.
- rd_en on empty is ignored: no pop, and rd_valid stays 0.
- fifo_level updates on the same edge as the push or pop.
- FSM:
  - RUN -> ENDING when test_ending=1.
  - ENDING -> ENDED when (serialiser idle and FIFO empty) or test_has_ended=1.
  - RUN -> ENDED directly when test_has_ended=1; test_has_ended has priority over test_ending.
  - ENDED is terminal until reset. done=1 in ENDED.
- In ENDING, an in-flight word finishes serialising and no new word is accepted.
- Forced ENDED (test_has_ended): the serialiser is aborted and its remaining slots are discarded. Discarded slots are not counted as dropped.
- Reads remain legal in every state. The FIFO retains its contents in ENDED.
- Reset mid-operation clears the FIFO, serialiser, FSM and all sticky flags immediately.

Decomposition:
- Package nios2_oci_trace_pkg holds:
  - the state enum (RUN/ENDING/ENDED) and its 2-bit encoding;
  - a function extracting slot k from the packed buffer;
  - a saturating-increment helper.
- One natural sub-module: nios2_oci_trace_fifo, a synchronous single-clock FIFO with full/empty/level outputs and same-edge push/pop when full.
- The serialiser and FSM stay in the top module.

Test Plan:
- Single word, defaults: dct_buffer={10'h3,10'h2,10'h1}, dct_count=3 -> pushes on t+1..t+3, dct_ready low for 3 cycles; three rd_en give rd_data 1,2,3, with rd_valid one cycle after each rd_en.
- Zero/over count: dct_count=0 -> fifo_level stays 0 and dct_ready stays 1. dct_count=7 -> count_err=1 and 3 slots are pushed.
- Overflow: 6 words of 3 slots (18 slots), no reads, DEPTH=16 -> fifo_level=16, overflow=1, dropped=2. Then pop+push on the same edge while full -> level stays 16.
- Graceful end: test_ending during slot 1 of a 3-slot word -> remaining slots are pushed and dct_ready=0; drain by reads -> ENDED on the edge after the FIFO empties, done=1.
- Forced end: test_has_ended while 2 slots are pending -> ENDED next edge, level excludes the aborted slots, dropped unchanged.
- Async reset asserted mid-serialisation, between clock edges -> all outputs return to reset values immediately; dct_ready=1 after release.

Source files
------------

// File: rtl/nios2_oci_trace_capture_pkg.sv
// Shared types and helpers for the OCI trace capture engine.
package nios2_oci_trace_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_ENDING = 2'd1,
    ST_ENDED  = 2'd2
  } trace_state_e;

  localparam int MAX_BUF_W  = 1024;
  localparam int MAX_SLOT_W = 64;

  // Slot k of a packed buffer, slot 0 in the LSBs; caller truncates to its slot width.
  function automatic logic [MAX_SLOT_W-1:0] get_slot(input logic [MAX_BUF_W-1:0] buffer,
                                                     input int k, input int slot_w);
    logic [MAX_BUF_W-1:0]  sh;
    logic [MAX_SLOT_W-1:0] mask;
    sh   = buffer >> (k * slot_w);
    mask = (slot_w >= MAX_SLOT_W) ? '1 : ((MAX_SLOT_W'(1) << slot_w) - MAX_SLOT_W'(1));
    return sh[MAX_SLOT_W-1:0] & mask;
  endfunction

  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] max_v;
    max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

endpackage

// File: rtl/nios2_oci_trace_capture_if.sv
// DCT offer and slot read-port signals of the trace capture engine.
interface nios2_oci_trace_capture_if #(
    parameter int SLOT_W = 10,
    parameter int SLOTS  = 3,
    parameter int CNT_W  = 4
);
    logic [SLOT_W*SLOTS-1:0] dct_buffer;
    logic [CNT_W-1:0]        dct_count;
    logic                    dct_valid;
    logic                    dct_ready;
    logic                    rd_en;
    logic [SLOT_W-1:0]       rd_data;
    logic                    rd_valid;

    modport master (
        output dct_buffer, dct_count, dct_valid, rd_en,
        input  dct_ready, rd_data, rd_valid
    );

    modport slave (
        input  dct_buffer, dct_count, dct_valid, rd_en,
        output dct_ready, rd_data, rd_valid
    );
endinterface

// File: rtl/nios2_oci_trace_capture_fifo.sv
// Single-clock slot FIFO; a push while full only lands when a pop frees the head on the same edge.
module nios2_oci_trace_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push, do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign level   = cnt;
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/nios2_oci_trace_capture.sv
// Captures multi-slot DCT words, serialises valid slots into a FIFO, tracks test-end sequencing.
module nios2_oci_trace_capture
    import nios2_oci_trace_pkg::*;
#(
    parameter int SLOT_W = 10,
    parameter int SLOTS  = 3,
    parameter int CNT_W  = 4,
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    nios2_oci_trace_capture_if.slave  bus,
    input  logic                      test_ending,
    input  logic                      test_has_ended,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic                      overflow,
    output logic                      count_err,
    output logic [DROP_W-1:0]         dropped,
    output logic [1:0]                state,
    output logic                      done
);
    localparam int IW = (SLOTS > 1) ? $clog2(SLOTS + 1) : 1;

    trace_state_e            state_q, state_d;
    logic [SLOT_W*SLOTS-1:0] buf_q;
    logic [IW-1:0]           n_q, idx_q, n_d;
    logic                    busy_q;
    logic                    accept, cnt_over, force_end, push, pop_ok;
    logic                    fifo_full, fifo_empty;
    logic [SLOT_W-1:0]       slot_data, head;

    assign bus.dct_ready = (state_q == ST_RUN) && !busy_q;
    assign accept        = bus.dct_valid && bus.dct_ready;
    assign cnt_over      = int'(bus.dct_count) > SLOTS;
    assign n_d           = cnt_over ? IW'(SLOTS) : IW'(bus.dct_count);
    // A forced end aborts the in-flight word, including the slot due on this edge.
    assign force_end     = test_has_ended && (state_q != ST_ENDED);
    assign push          = busy_q && !force_end;
    assign pop_ok        = bus.rd_en && !fifo_empty;
    assign slot_data     = SLOT_W'(get_slot(MAX_BUF_W'(buf_q), int'(idx_q), SLOT_W));

    nios2_oci_trace_fifo #(.W(SLOT_W), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (reset_n),
        .push      (push),
        .push_data (slot_data),
        .pop       (bus.rd_en),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_RUN;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (test_has_ended)   state_d = ST_ENDED;
                else if (test_ending) state_d = ST_ENDING;
            end
            ST_ENDING: begin
                if (test_has_ended || (!busy_q && fifo_empty)) state_d = ST_ENDED;
            end
            default: state_d = ST_ENDED;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_q     <= '0;
            n_q       <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            count_err <= 1'b0;
        end else begin
            if (accept && cnt_over) count_err <= 1'b1;
            if (force_end) begin
                busy_q <= 1'b0;
            end else if (accept) begin
                buf_q  <= bus.dct_buffer;
                n_q    <= n_d;
                idx_q  <= '0;
                busy_q <= (n_d != '0);
            end else if (busy_q) begin
                idx_q <= idx_q + 1'b1;
                if (idx_q == n_q - 1'b1) busy_q <= 1'b0;
            end
        end
    end

    // A slot is lost only when the FIFO is full and no pop frees a place on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
            dropped  <= '0;
        end else if (push && fifo_full && !pop_ok) begin
            overflow <= 1'b1;
            dropped  <= DROP_W'(sat_inc(64'(dropped), DROP_W));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
        end else begin
            bus.rd_valid <= pop_ok;
            if (pop_ok) bus.rd_data <= head;
        end
    end

    assign state = state_q;
    assign done  = (state_q == ST_ENDED);
endmodule

// File: tb/tb_nios2_oci_trace_capture.sv
// Directed bench for the trace capture engine with hand-computed expectations.
module tb_nios2_oci_trace_capture;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        test_ending, test_has_ended;
    logic [4:0]  fifo_level;
    logic        overflow, count_err, done;
    logic [15:0] dropped;
    logic [1:0]  state;
    int          n_chk = 0;
    int          n_err = 0;

    nios2_oci_trace_capture_if #(.SLOT_W(10), .SLOTS(3), .CNT_W(4)) bus ();

    nios2_oci_trace_capture #(
        .SLOT_W(10), .SLOTS(3), .CNT_W(4), .DEPTH(16), .DROP_W(16)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .bus            (bus),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended),
        .fifo_level     (fifo_level),
        .overflow       (overflow),
        .count_err      (count_err),
        .dropped        (dropped),
        .state          (state),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [29:0] b, input logic [3:0] c);
        bus.dct_buffer = b;
        bus.dct_count  = c;
        bus.dct_valid  = 1'b1;
        tick();
        bus.dct_valid  = 1'b0;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [29:0] w;
        reset_n = 1'b0; test_ending = 1'b0; test_has_ended = 1'b0;
        bus.dct_buffer = '0; bus.dct_count = '0; bus.dct_valid = 1'b0; bus.rd_en = 1'b0;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_ready", 32'(bus.dct_ready), 32'd1);
        chk("rst_rdv", 32'(bus.rd_valid), 32'd0);
        chk("rst_flags", {29'd0, overflow, count_err, done}, 32'd0);
        chk("rst_dropped", 32'(dropped), 32'd0);
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // Single 3-slot word, then three reads
        offer({10'h3, 10'h2, 10'h1}, 4'd3);
        chk("w1_ready_t0", 32'(bus.dct_ready), 32'd0);
        chk("w1_level_t0", 32'(fifo_level), 32'd0);
        tick(); chk("w1_level_t1", 32'(fifo_level), 32'd1);
        chk("w1_ready_t1", 32'(bus.dct_ready), 32'd0);
        tick(); chk("w1_level_t2", 32'(fifo_level), 32'd2);
        tick(); chk("w1_level_t3", 32'(fifo_level), 32'd3);
        chk("w1_ready_t3", 32'(bus.dct_ready), 32'd1);
        bus.rd_en = 1'b1;
        tick(); chk("rd1_valid", 32'(bus.rd_valid), 32'd1); chk("rd1_data", 32'(bus.rd_data), 32'h1);
        tick(); chk("rd2_data", 32'(bus.rd_data), 32'h2);
        tick(); chk("rd3_data", 32'(bus.rd_data), 32'h3); chk("rd3_level", 32'(fifo_level), 32'd0);
        tick(); chk("rd_empty_valid", 32'(bus.rd_valid), 32'd0);
        chk("rd_hold_data", 32'(bus.rd_data), 32'h3);
        bus.rd_en = 1'b0;

        // Zero count, then over-count
        offer(30'h1, 4'd0);
        chk("zero_ready", 32'(bus.dct_ready), 32'd1);
        tick(); chk("zero_level", 32'(fifo_level), 32'd0);
        offer({10'h3C, 10'h2B, 10'h1A}, 4'd7);
        chk("over_cerr", 32'(count_err), 32'd1);
        repeat (3) tick();
        chk("over_level", 32'(fifo_level), 32'd3);
        bus.rd_en = 1'b1;
        tick(); chk("over_rd0", 32'(bus.rd_data), 32'h1A);
        tick(); chk("over_rd1", 32'(bus.rd_data), 32'h2B);
        tick(); chk("over_rd2", 32'(bus.rd_data), 32'h3C);
        bus.rd_en = 1'b0;
        chk("over_cerr_sticky", 32'(count_err), 32'd1);
        pulse_reset();
        chk("cerr_cleared", 32'(count_err), 32'd0);

        // Overflow: 18 slots into 16 places
        for (int i = 0; i < 6; i++) begin
            w = {10'(3*i+2), 10'(3*i+1), 10'(3*i)};
            offer(w, 4'd3);
            repeat (3) tick();
        end
        chk("ovf_level", 32'(fifo_level), 32'd16);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_dropped", 32'(dropped), 32'd2);
        offer(30'h55, 4'd1);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        chk("full_pushpop_level", 32'(fifo_level), 32'd16);
        chk("full_pushpop_data", 32'(bus.rd_data), 32'h0);
        chk("full_pushpop_dropped", 32'(dropped), 32'd2);
        pulse_reset();

        // Graceful end during slot 1
        offer({10'h9, 10'h8, 10'h7}, 4'd3);
        tick();
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        chk("end_state", 32'(state), 32'd1);
        chk("end_ready", 32'(bus.dct_ready), 32'd0);
        chk("end_level2", 32'(fifo_level), 32'd2);
        tick(); chk("end_level3", 32'(fifo_level), 32'd3);
        offer(30'h3FF, 4'd3);
        tick(); chk("end_no_accept", 32'(fifo_level), 32'd3);
        bus.rd_en = 1'b1;
        tick(); chk("end_rd0", 32'(bus.rd_data), 32'h7);
        tick(); tick(); chk("end_rd2", 32'(bus.rd_data), 32'h9);
        bus.rd_en = 1'b0;
        chk("end_still_ending", 32'(state), 32'd1);
        tick();
        chk("end_ended", 32'(state), 32'd2);
        chk("end_done", 32'(done), 32'd1);
        pulse_reset();

        // Forced end with two slots pending
        offer({10'h33, 10'h22, 10'h11}, 4'd3);
        tick(); chk("force_pre_level", 32'(fifo_level), 32'd1);
        test_has_ended = 1'b1;
        tick();
        test_has_ended = 1'b0;
        chk("force_state", 32'(state), 32'd2);
        chk("force_done", 32'(done), 32'd1);
        chk("force_level", 32'(fifo_level), 32'd1);
        chk("force_dropped", 32'(dropped), 32'd0);
        tick(); chk("force_level_after", 32'(fifo_level), 32'd1);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        chk("force_rd_valid", 32'(bus.rd_valid), 32'd1);
        chk("force_rd_data", 32'(bus.rd_data), 32'h11);
        pulse_reset();

        // Async reset between edges mid-serialisation
        offer({10'h6, 10'h5, 10'h4}, 4'd9);
        tick();
        #3 reset_n = 1'b0;
        #1;
        chk("areset_level", 32'(fifo_level), 32'd0);
        chk("areset_ready", 32'(bus.dct_ready), 32'd1);
        chk("areset_state", 32'(state), 32'd0);
        chk("areset_cerr", 32'(count_err), 32'd0);
        chk("areset_rdv", 32'(bus.rd_valid), 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        tick();
        chk("arel_ready", 32'(bus.dct_ready), 32'd1);
        chk("arel_level", 32'(fifo_level), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
